lcd_timing_gen: RTL and testbench

//  - Raster timing generator for the 800x480 LCD panel; sits directly upstream of the pixel colour stage.
//  - Produces pixel coordinates, active-region flag, vertical-blank flag, colour-stage enable and panel sync/DE.
//  - Holds the colour stage disabled (black) for the first STARTUP_FRAMES frames after reset.

---
 rtl/lcd_timing_pkg.sv | 39 +++
 rtl/lcd_sync_delay.sv | 46 ++++
 rtl/lcd_timing_gen.sv | 142 ++++++++++++++
 tb/tb_lcd_timing_gen.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/lcd_timing_pkg.sv
// Default 800x480 panel timing, counter widths and shared types for the LCD raster generator.
package lcd_timing_pkg;

  localparam int H_ACTIVE = 800;
  localparam int H_FP     = 40;
  localparam int H_SYNC   = 128;
  localparam int H_BP     = 88;
  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;

  localparam int V_ACTIVE = 480;
  localparam int V_FP     = 13;
  localparam int V_SYNC   = 3;
  localparam int V_BP     = 29;
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam int HCNT_W = 11;
  localparam int VCNT_W = 10;
  localparam int POS_W  = 10;
  localparam int SCNT_W = 8;
  localparam int FCNT_W = 16;

  typedef enum logic {
    ST_STARTUP = 1'b0,
    ST_RUN     = 1'b1
  } startup_state_e;

  typedef struct packed {
    logic hsync_n;
    logic vsync_n;
    logic de;
  } sync_t;

  localparam sync_t SYNC_IDLE = '{hsync_n: 1'b1, vsync_n: 1'b1, de: 1'b0};

  function automatic logic in_window(input int cnt, input int start, input int len);
    return (cnt >= start) && (cnt < start + len);
  endfunction

endpackage

// File: rtl/lcd_sync_delay.sv
// Fixed-depth shift register aligning panel sync/DE with the downstream colour-stage latency.
// DEPTH=0 is a straight wire; reset loads RST_VAL into every stage.
module lcd_sync_delay
  import lcd_timing_pkg::*;
#(
  parameter int                DEPTH   = 1,
  parameter int                WIDTH   = 3,
  parameter logic [WIDTH-1:0]  RST_VAL = WIDTH'(SYNC_IDLE)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] in_dat,
  output logic [WIDTH-1:0] out_dat
);

  generate
    if (DEPTH == 0) begin : g_pass
      assign out_dat = in_dat;
    end else begin : g_shift
      logic [WIDTH-1:0] stage_q [DEPTH];
      logic [WIDTH-1:0] stage_d [DEPTH];

      always_comb begin
        stage_d[0] = in_dat;
        for (int i = 1; i < DEPTH; i++) begin
          stage_d[i] = stage_q[i-1];
        end
      end

      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          for (int i = 0; i < DEPTH; i++) begin
            stage_q[i] <= RST_VAL;
          end
        end else begin
          for (int i = 0; i < DEPTH; i++) begin
            stage_q[i] <= stage_d[i];
          end
        end
      end

      assign out_dat = stage_q[DEPTH-1];
    end
  endgenerate

endmodule

// File: rtl/lcd_timing_gen.sv
// Raster timing generator for the LCD panel: counters, registered coordinates/flags, startup blanking.
// Define LCD_TIMING_FRAME_CNT_EN to add the frame_cnt output.
module lcd_timing_gen #(
  parameter int H_ACTIVE       = lcd_timing_pkg::H_ACTIVE,
  parameter int H_FP           = lcd_timing_pkg::H_FP,
  parameter int H_SYNC         = lcd_timing_pkg::H_SYNC,
  parameter int H_BP           = lcd_timing_pkg::H_BP,
  parameter int V_ACTIVE       = lcd_timing_pkg::V_ACTIVE,
  parameter int V_FP           = lcd_timing_pkg::V_FP,
  parameter int V_SYNC         = lcd_timing_pkg::V_SYNC,
  parameter int V_BP           = lcd_timing_pkg::V_BP,
  parameter int STARTUP_FRAMES = 10,
  parameter int OUT_DELAY      = 1
) (
  input  logic        clk,
  input  logic        reset_n,
  output logic [9:0]  x_pos,
  output logic [9:0]  y_pos,
  output logic        valid_region,
  output logic        v_blank,
  output logic        en,
  output logic        lcd_hsync_n,
  output logic        lcd_vsync_n,
  output logic        lcd_de
`ifdef LCD_TIMING_FRAME_CNT_EN
  ,
  output logic [15:0] frame_cnt
`endif
);
  import lcd_timing_pkg::*;

  localparam int H_TOT = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOT = V_ACTIVE + V_FP + V_SYNC + V_BP;

  logic [HCNT_W-1:0] h_cnt_q, h_cnt_d;
  logic [VCNT_W-1:0] v_cnt_q, v_cnt_d;
  logic [POS_W-1:0]  x_pos_q, x_pos_d;
  logic [POS_W-1:0]  y_pos_q, y_pos_d;
  logic              valid_q, valid_d;
  logic              v_blank_q, v_blank_d;
  sync_t             sync_q, sync_d;
  logic [SCNT_W-1:0] start_cnt_q, start_cnt_d;
  startup_state_e    state_q, state_d;
  logic              h_wrap;
  logic              vb_rise;
  sync_t             lcd_sync;

  always_comb begin
    h_wrap  = (int'(h_cnt_q) == H_TOT - 1);
    h_cnt_d = h_wrap ? '0 : h_cnt_q + 1'b1;
    v_cnt_d = v_cnt_q;
    if (h_wrap) begin
      v_cnt_d = (int'(v_cnt_q) == V_TOT - 1) ? '0 : v_cnt_q + 1'b1;
    end

    // Everything below describes the current count and is registered together.
    valid_d   = (int'(h_cnt_q) < H_ACTIVE) && (int'(v_cnt_q) < V_ACTIVE);
    v_blank_d = (int'(v_cnt_q) >= V_ACTIVE);
    x_pos_d   = valid_d ? h_cnt_q[POS_W-1:0] : '0;
    y_pos_d   = valid_d ? v_cnt_q[POS_W-1:0] : '0;

    sync_d.hsync_n = !in_window(int'(h_cnt_q), H_ACTIVE + H_FP, H_SYNC);
    sync_d.vsync_n = !in_window(int'(v_cnt_q), V_ACTIVE + V_FP, V_SYNC);
    sync_d.de      = valid_d;

    vb_rise     = v_blank_d && !v_blank_q;
    start_cnt_d = start_cnt_q;
    if (vb_rise && (int'(start_cnt_q) < STARTUP_FRAMES)) begin
      start_cnt_d = start_cnt_q + 1'b1;
    end

    // Enable only at a frame boundary so the colour stage never starts mid-frame.
    state_d = state_q;
    if ((state_q == ST_STARTUP) && (int'(start_cnt_q) == STARTUP_FRAMES) &&
        (h_cnt_q == '0) && (v_cnt_q == '0)) begin
      state_d = ST_RUN;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      h_cnt_q     <= '0;
      v_cnt_q     <= '0;
      x_pos_q     <= '0;
      y_pos_q     <= '0;
      valid_q     <= 1'b0;
      v_blank_q   <= 1'b0;
      sync_q      <= SYNC_IDLE;
      start_cnt_q <= '0;
      state_q     <= ST_STARTUP;
    end else begin
      h_cnt_q     <= h_cnt_d;
      v_cnt_q     <= v_cnt_d;
      x_pos_q     <= x_pos_d;
      y_pos_q     <= y_pos_d;
      valid_q     <= valid_d;
      v_blank_q   <= v_blank_d;
      sync_q      <= sync_d;
      start_cnt_q <= start_cnt_d;
      state_q     <= state_d;
    end
  end

`ifdef LCD_TIMING_FRAME_CNT_EN
  logic [FCNT_W-1:0] frame_cnt_q, frame_cnt_d;

  always_comb begin
    frame_cnt_d = vb_rise ? frame_cnt_q + 1'b1 : frame_cnt_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      frame_cnt_q <= '0;
    end else begin
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign frame_cnt = frame_cnt_q;
`endif

  lcd_sync_delay #(
    .DEPTH   (OUT_DELAY),
    .WIDTH   (3),
    .RST_VAL (SYNC_IDLE)
  ) u_sync_delay (
    .clk     (clk),
    .reset_n (reset_n),
    .in_dat  (sync_q),
    .out_dat (lcd_sync)
  );

  assign x_pos        = x_pos_q;
  assign y_pos        = y_pos_q;
  assign valid_region = valid_q;
  assign v_blank      = v_blank_q;
  assign en           = (state_q == ST_RUN);
  assign lcd_hsync_n  = lcd_sync.hsync_n;
  assign lcd_vsync_n  = lcd_sync.vsync_n;
  assign lcd_de       = lcd_sync.de;

endmodule

// File: tb/tb_lcd_timing_gen.sv
// Randomized bench for lcd_timing_gen on a shrunken raster, checked against a closed-form timing model.
module tb_lcd_timing_gen;

  localparam int HA = 8, HF = 2, HS = 3, HB = 2;
  localparam int VA = 4, VF = 1, VS = 2, VB = 1;
  localparam int SF = 3, OD = 2;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int FR = HT * VT;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [9:0] x_pos, y_pos;
  logic       valid_region, v_blank, en;
  logic       lcd_hsync_n, lcd_vsync_n, lcd_de;
`ifdef LCD_TIMING_FRAME_CNT_EN
  logic [15:0] frame_cnt;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  int t        = 0;   // rising edges since reset release; 0 while in reset
  int fc_off   = 0;
  logic prev_en = 1'b0;

  lcd_timing_gen #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .STARTUP_FRAMES(SF), .OUT_DELAY(OD)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .x_pos        (x_pos),
    .y_pos        (y_pos),
    .valid_region (valid_region),
    .v_blank      (v_blank),
    .en           (en),
    .lcd_hsync_n  (lcd_hsync_n),
    .lcd_vsync_n  (lcd_vsync_n),
    .lcd_de       (lcd_de)
`ifdef LCD_TIMING_FRAME_CNT_EN
    ,
    .frame_cnt    (frame_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0d)", tag, act, exp, t);
    end
  endtask

  // Number of blanking starts seen by output cycle tt.
  function automatic int vb_edges(input int tt);
    if (tt < 1 || (tt - 1) < VA * HT) return 0;
    return (tt - 1 - VA * HT) / FR + 1;
  endfunction

  task automatic check_all();
    int idx, h, v;
    int ex, ey, evld, evb, een, ehs, evs, ede;
    if (t == 0) begin
      ex = 0; ey = 0; evld = 0; evb = 0; een = 0;
    end else begin
      idx  = t - 1;
      h    = idx % HT;
      v    = (idx / HT) % VT;
      evld = (h < HA && v < VA) ? 1 : 0;
      ex   = evld ? h : 0;
      ey   = evld ? v : 0;
      evb  = (v >= VA) ? 1 : 0;
      een  = ((idx / FR) >= SF) ? 1 : 0;
    end
    if (t - OD < 1) begin
      ehs = 1; evs = 1; ede = 0;
    end else begin
      idx = t - OD - 1;
      h   = idx % HT;
      v   = (idx / HT) % VT;
      ehs = (h >= HA + HF && h < HA + HF + HS) ? 0 : 1;
      evs = (v >= VA + VF && v < VA + VF + VS) ? 0 : 1;
      ede = (h < HA && v < VA) ? 1 : 0;
    end
    check("x_pos", 32'(x_pos), 32'(ex));
    check("y_pos", 32'(y_pos), 32'(ey));
    check("valid_region", 32'(valid_region), 32'(evld));
    check("v_blank", 32'(v_blank), 32'(evb));
    check("en", 32'(en), 32'(een));
    check("lcd_hsync_n", 32'(lcd_hsync_n), 32'(ehs));
    check("lcd_vsync_n", 32'(lcd_vsync_n), 32'(evs));
    check("lcd_de", 32'(lcd_de), 32'(ede));
    if (en === 1'b1 && prev_en === 1'b0) begin
      check("en_rise_xy", {22'd0, x_pos} | {22'd0, y_pos}, 32'd0);
    end
    prev_en = en;
`ifdef LCD_TIMING_FRAME_CNT_EN
    check("frame_cnt", 32'(frame_cnt), 32'((vb_edges(t) + fc_off) & 16'hFFFF));
`endif
  endtask

  task automatic run(input int n);
    repeat (n) begin
      @(posedge clk);
      t++;
      @(negedge clk);
      check_all();
    end
  endtask

  // Asserted between edges so the clear is visibly asynchronous.
  task automatic async_reset(input int len);
    #($urandom_range(1, 3));
    reset_n = 1'b0;
    #1;
    t = 0;
    fc_off = 0;
    check_all();
    repeat (len) @(negedge clk);
    check_all();
    reset_n = 1'b1;
  endtask

  task automatic run_to_line(input int line, input int col);
    int found = 0;
    for (int i = 0; i < 2 * FR && found == 0; i++) begin
      run(1);
      if (((t - 1) / HT) % VT == line && (t - 1) % HT == col) found = 1;
    end
    check("run_to_line_found", 32'(found), 32'd1);
  endtask

  initial begin
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    t = 0;
    check_all();
    reset_n = 1'b1;

    // Startup blanking, then several enabled frames.
    run(FR * (SF + 3) + $urandom_range(0, HT));

    // Mid-frame reset in the active region, then the whole startup again.
    run_to_line(2, $urandom_range(0, HT - 1));
    async_reset($urandom_range(1, 4));
    run(FR * (SF + 2));

    for (int k = 0; k < 5; k++) begin
      run($urandom_range(1, 3 * FR));
      async_reset($urandom_range(1, 5));
    end
    run(FR * (SF + 2) + $urandom_range(0, FR));

`ifdef LCD_TIMING_FRAME_CNT_EN
    // Preload the counter away from any blanking edge and confirm wraparound.
    run_to_line(1, 1);
    force dut.frame_cnt_q = 16'hFFFF;
    #1;
    check("frame_cnt_forced", 32'(frame_cnt), 32'hFFFF);
    @(posedge clk);
    t++;
    #1;
    release dut.frame_cnt_q;
    fc_off = 65535 - vb_edges(t);
    @(negedge clk);
    check_all();
    run(2 * FR);
    check("frame_cnt_wrapped", 32'(frame_cnt), 32'((vb_edges(t) + fc_off) & 16'hFFFF));
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL timeout: simulation did not reach the summary (t=%0d)", t);
    $fatal(1, "timeout");
  end

endmodule
